exp_sub_pipe: RTL

- Pipelined exponent datapath for the FP divide/square-root unit; the subtractive counterpart of the 13-bit exponent adder.
- Divide mode: computes the quotient exponent ea - eb + BIAS.
- Sqrt mode: computes the root exponent (ea + BIAS) >> 1 and reports the odd bit, which drives mantissa pre-shift.
- Two-stage valid/ready pipeline between operand unpack and the divsqrt iteration controller; flags overflow/underflow of the pre-normalised exponent.

---
 rtl/exp_sub_pipe.sv | 122 ++++++++++++
 1 files changed

// File: rtl/exp_sub_pipe.sv
// exp_sub_pipe: two-stage valid/ready exponent datapath for the FP divide/sqrt unit.
// Define EXP_SUB_SATURATE_EN to clamp overflowing results to EMAX+1 and underflowing results to 0.
module exp_sub_pipe #(
  parameter int WIDTH = 13,
  parameter int BIAS  = 1023,
  parameter int EMAX  = 2046
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sqrt_op,
  input  logic [WIDTH-1:0] ea,
  input  logic [WIDTH-1:0] eb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic             odd,
  output logic             ovf,
  output logic             unf
);

  localparam int IW = WIDTH + 2;
  localparam logic signed [IW-1:0] BIAS_S = IW'(BIAS);
  localparam logic signed [IW-1:0] EMAX_S = IW'(EMAX);
  localparam logic signed [IW-1:0] ONE_S  = IW'(1);

  logic                 r_s1Valid;
  logic                 r_s1Sqrt;
  logic signed [IW-1:0] r_d;
  logic                 r_s2Valid;
  logic [WIDTH-1:0]     r_q;
  logic                 r_odd;
  logic                 r_ovf;
  logic                 r_unf;

  logic                 w_s2Adv;
  logic                 w_s1Adv;
  logic                 w_accept;
  logic signed [IW-1:0] w_eaX;
  logic signed [IW-1:0] w_ebX;
  logic signed [IW-1:0] w_d;
  logic signed [IW-1:0] w_r;
  logic [WIDTH-1:0]     w_q;
  logic                 w_odd;
  logic                 w_ovf;
  logic                 w_unf;

  // No skid buffer: in_ready ripples combinationally back from out_ready.
  assign w_s2Adv  = !r_s2Valid || out_ready;
  assign w_s1Adv  = !r_s1Valid || w_s2Adv;
  assign in_ready = w_s1Adv && !flush;
  assign w_accept = in_valid && in_ready;

  assign w_eaX = {2'b00, ea};
  assign w_ebX = {2'b00, eb};
  assign w_d   = sqrt_op ? (w_eaX + BIAS_S) : (w_eaX + ~w_ebX + ONE_S);

  always_comb begin
    w_r   = r_d + BIAS_S;
    w_odd = 1'b0;
    if (r_s1Sqrt) begin
      w_r   = r_d >>> 1;
      w_odd = r_d[0];
    end
    w_ovf = (w_r > EMAX_S);
    w_unf = (w_r < ONE_S);
`ifdef EXP_SUB_SATURATE_EN
    if (w_ovf) begin
      w_q = WIDTH'(EMAX + 1);
    end else if (w_unf) begin
      w_q = '0;
    end else begin
      w_q = w_r[WIDTH-1:0];
    end
`else
    w_q = w_r[WIDTH-1:0];
`endif
  end

  // Flush clears only the valid bits; data registers keep their contents.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1Valid <= 1'b0;
      r_s1Sqrt  <= 1'b0;
      r_d       <= '0;
      r_s2Valid <= 1'b0;
      r_q       <= '0;
      r_odd     <= 1'b0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
    end else if (flush) begin
      r_s1Valid <= 1'b0;
      r_s2Valid <= 1'b0;
    end else begin
      if (w_s1Adv) begin
        r_s1Valid <= in_valid;
      end
      if (w_accept) begin
        r_d      <= w_d;
        r_s1Sqrt <= sqrt_op;
      end
      if (w_s2Adv) begin
        r_s2Valid <= r_s1Valid;
        if (r_s1Valid) begin
          r_q   <= w_q;
          r_odd <= w_odd;
          r_ovf <= w_ovf;
          r_unf <= w_unf;
        end
      end
    end
  end

  assign out_valid = r_s2Valid;
  assign q         = r_q;
  assign odd       = r_odd;
  assign ovf       = r_ovf;
  assign unf       = r_unf;

endmodule
